// File: rtl/stp_pkg.sv
// Shared definitions for the stopwatch control path.
//   stp_state_t  : control FSM state encoding (IDLE/RUN/LAP/PAUSE).
//   STP_TICK_DIV : default CLK cycles per seconds tick. The display mux
//                  and the testbench reuse this value.
package stp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } stp_state_t;

    localparam int STP_TICK_DIV = 50_000_000;

endpackage

// File: rtl/stp_ctrl_if.sv
// Button/strobe bundle between the button front end and the stopwatch
// counter chain.
//   btn_start_stop, btn_lap, btn_reset : debounced button levels
//   count_up_sec  : one-cycle seconds tick to the seconds counter
//   stop          : level, holds the counters at zero while idle
//   rst_counters  : one-cycle clear pulse to all counters
//   lap_hold      : display shows the frozen value
//   running       : LED indicator, high in RUN or LAP
// The slave modport is the controller side; master is the driving side.
interface stp_ctrl_if;

    logic btn_start_stop;
    logic btn_lap;
    logic btn_reset;
    logic count_up_sec;
    logic stop;
    logic rst_counters;
    logic lap_hold;
    logic running;

    modport master (
        output btn_start_stop, btn_lap, btn_reset,
        input  count_up_sec, stop, rst_counters, lap_hold, running
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_reset,
        output count_up_sec, stop, rst_counters, lap_hold, running
    );

endinterface

// File: rtl/stp_tick_gen.sv
// Seconds prescaler. Counts 0..TICK_DIV-1 while en is high, holds its
// value while en is low, and returns to 0 when clr is high.
//   CLK, rst_n : clock, asynchronous active-low reset
//   en         : count enable (watch running)
//   clr        : synchronous clear of the prescaler
//   tick       : registered one-cycle pulse issued as the count wraps
module stp_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] presc_q, presc_d;
    logic         tick_q, tick_d;

    // NOTE: every variable gets its default before any branch so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + W'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/stp_ctrl.sv
// Stopwatch control FSM. Edge-detects the three debounced buttons,
// steps IDLE/RUN/LAP/PAUSE and produces the counter-chain strobes.
//   CLK, rst_n : clock, asynchronous active-low reset
//   bus        : stp_ctrl_if.slave (button levels in, strobes out)
// stop/lap_hold/running decode straight from the state register;
// count_up_sec and rst_counters are registered pulses.
module stp_ctrl
    import stp_pkg::*;
#(
    parameter int TICK_DIV = STP_TICK_DIV
) (
    input  logic         CLK,
    input  logic         rst_n,
    stp_ctrl_if.slave    bus
);

    stp_state_t state_q, state_d;
    logic       btn_start_stop_q, btn_lap_q, btn_reset_q;
    logic       rst_counters_q, rst_counters_d;
    logic       start_stop_rise, lap_rise, reset_rise;
    logic       presc_en, presc_clr, tick;

    assign start_stop_rise = bus.btn_start_stop & ~btn_start_stop_q;
    assign lap_rise        = bus.btn_lap        & ~btn_lap_q;
    assign reset_rise      = bus.btn_reset      & ~btn_reset_q;

    // Within each state, rises are tested in priority order
    // reset > start_stop > lap, skipping those illegal in that state.
    always_comb begin
        state_d        = state_q;
        rst_counters_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_stop_rise) state_d = RUN;
            end
            RUN: begin
                if (start_stop_rise)  state_d = PAUSE;
                else if (lap_rise)    state_d = LAP;
            end
            LAP: begin
                if (start_stop_rise)  state_d = PAUSE;
                else if (lap_rise)    state_d = RUN;
            end
            PAUSE: begin
                if (reset_rise) begin
                    state_d        = IDLE;
                    rst_counters_d = 1'b1;
                end else if (start_stop_rise) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            btn_start_stop_q <= 1'b0;
            btn_lap_q        <= 1'b0;
            btn_reset_q      <= 1'b0;
            rst_counters_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            btn_start_stop_q <= bus.btn_start_stop;
            btn_lap_q        <= bus.btn_lap;
            btn_reset_q      <= bus.btn_reset;
            rst_counters_q   <= rst_counters_d;
        end
    end

    // The prescaler runs off the current state, so the tick due in the
    // last RUN cycle before a pause is still issued. Clearing on the
    // reset action itself leaves presc at 0 during the rst_counters cycle.
    assign presc_en  = (state_q == RUN) || (state_q == LAP);
    assign presc_clr = (state_q == IDLE) || rst_counters_d;

    stp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLK   (CLK),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    assign bus.count_up_sec = tick;
    assign bus.rst_counters = rst_counters_q;
    assign bus.stop         = (state_q == IDLE);
    assign bus.lap_hold     = (state_q == LAP);
    assign bus.running      = (state_q == RUN) || (state_q == LAP);

endmodule

// File: tb/tb_stp_ctrl.sv
// Testbench for stp_ctrl with TICK_DIV = 4. Stimulus tasks drive button
// levels, step a reference model of the stopwatch (transition table plus
// elapsed-running-cycle count) and queue the expected outputs; a monitor
// compares the DUT outputs against the queue on every falling edge.
module tb_stp_ctrl;

    localparam int TD = 4;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    stp_ctrl_if bus ();

    stp_ctrl #(.TICK_DIV(TD)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Output vector order: tick, rst_counters, stop, lap_hold, running.
    typedef struct packed {
        logic tick;
        logic rstc;
        logic stop;
        logic lap_hold;
        logic running;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t o;
    } exp_t;

    exp_t sb_q[$];

    typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} mode_t;
    mode_t      mode = M_IDLE;
    int         run_cycles = 0;   // running cycles since last clear
    logic [2:0] prev_lvl = '0;    // {reset, start_stop, lap}

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got=%b want=%b", name, cyc, got, want);
        end
    endtask

    function automatic outs_t dut_outs();
        dut_outs = {bus.count_up_sec, bus.rst_counters, bus.stop, bus.lap_hold, bus.running};
    endfunction

    // Where button b (0=reset, 1=start_stop, 2=lap) takes mode m; m if ignored.
    function automatic mode_t dest(mode_t m, int b);
        dest = m;
        case (m)
            M_IDLE:  if (b == 1) dest = M_RUN;
            M_RUN:   if (b == 1) dest = M_PAUSE; else if (b == 2) dest = M_LAP;
            M_LAP:   if (b == 1) dest = M_PAUSE; else if (b == 2) dest = M_RUN;
            M_PAUSE: if (b == 0) dest = M_IDLE;  else if (b == 1) dest = M_RUN;
            default: dest = m;
        endcase
    endfunction

    // Called just after a rising edge: drive levels, predict the outputs
    // that follow the next edge, then advance to just after that edge.
    task automatic step(input logic ss, input logic lp, input logic rs);
        logic [2:0] lvl;
        logic [2:0] rise;
        bit         was_running;
        outs_t      e;
        bus.btn_start_stop = ss;
        bus.btn_lap        = lp;
        bus.btn_reset      = rs;
        lvl  = {rs, ss, lp};
        rise = lvl & ~prev_lvl;
        prev_lvl = lvl;
        e = '0;
        was_running = (mode == M_RUN) || (mode == M_LAP);
        if (was_running) run_cycles++;
        e.tick = was_running && (run_cycles % TD == 0);
        for (int b = 0; b < 3; b++) begin
            if (rise[2-b] && dest(mode, b) != mode) begin
                if (mode == M_PAUSE && b == 0) e.rstc = 1'b1;
                mode = dest(mode, b);
                break;
            end
        end
        if (mode == M_IDLE) run_cycles = 0;
        e.stop     = (mode == M_IDLE);
        e.lap_hold = (mode == M_LAP);
        e.running  = (mode == M_RUN) || (mode == M_LAP);
        sb_q.push_back('{cyc: cyc + 1, o: e});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react at once.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        bus.btn_start_stop = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.btn_reset      = 1'b0;
        #1;
        check("arst_stop", bus.stop, 1);
        check("arst_running", bus.running, 0);
        check("arst_tick", bus.count_up_sec, 0);
        check("arst_lap_hold", bus.lap_hold, 0);
        check("arst_rstc", bus.rst_counters, 0);
        sb_q.delete();
        mode       = M_IDLE;
        run_cycles = 0;
        prev_lvl   = '0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                if (sb_q[0].cyc < cyc) begin
                    e = sb_q.pop_front();
                    check("stale_expectation", 5'd1, 5'd0);
                end else if (sb_q[0].cyc == cyc) begin
                    e = sb_q.pop_front();
                    check("outs(tick,rstc,stop,lap,run)", dut_outs(), e.o);
                end
            end
        end
    end

    initial begin : stimulus
        logic ss, lp, rs;
        bus.btn_start_stop = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.btn_reset      = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", dut_outs(), 5'b00100);
        rst_n = 1'b1;

        idle(20);                               // no ticks while idle
        step(1, 0, 0); idle(13);                // start, ticks at k+4/8/12
        step(0, 1, 0); idle(9);                 // lap, ticks continue
        step(0, 1, 0); idle(3);                 // lap off
        step(0, 1, 0); idle(1);                 // lap again
        step(1, 0, 0); idle(3);                 // start_stop in LAP -> PAUSE
        step(0, 0, 1); idle(3);                 // reset from PAUSE
        step(1, 0, 0); idle(5);                 // start, tick, +2 cycles
        step(1, 0, 0); idle(10);                // pause holding phase
        step(1, 0, 0); idle(4);                 // resume, tick after 2
        step(0, 0, 1); idle(2);                 // reset ignored in RUN
        step(0, 1, 0); idle(1);
        step(0, 0, 1); idle(2);                 // reset ignored in LAP
        step(1, 0, 0); idle(1);                 // -> PAUSE
        step(1, 0, 1); idle(2);                 // reset+start in PAUSE -> IDLE
        step(1, 0, 0); idle(2);
        step(1, 1, 0); idle(2);                 // start+lap in RUN -> PAUSE
        repeat (8) step(1, 0, 0);               // held: one transition only
        idle(6);
        async_reset();                          // mid-RUN
        idle(20);

        ss = 0; lp = 0; rs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 15) ss = ~ss;
            if ($urandom_range(0, 99) < 12) lp = ~lp;
            if ($urandom_range(0, 99) < 10) rs = ~rs;
            if (i % 700 == 699) begin
                async_reset();
                ss = 0; lp = 0; rs = 0;
            end else begin
                step(ss, lp, rs);
            end
        end
        idle(2);
        repeat (2) @(negedge CLK);
        check("scoreboard_drained", sb_q.size() == 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stp_ctrl.md
# stp_ctrl

Stopwatch control FSM and seconds-tick generator for the stop-watch timer path. Converts debounced start/stop, lap and reset button levels into the control strobes consumed by the stopwatch second/minute/hour counter chain: a gated seconds tick (`count_up_sec`), a hold-at-zero level (`stop`) and a one-cycle clear pulse (`rst_counters`). It also drives a display-freeze level (`lap_hold`) for the display mux.

## Interface

**Parameters**
- `TICK_DIV`, default 50_000_000. CLK cycles per seconds tick. Must be ≥ 2.

**Ports** (clock and reset first)
- `CLK` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_start_stop` in 1: debounced level; acts on its rising edge.
- `btn_lap` in 1: debounced level; acts on its rising edge.
- `btn_reset` in 1: debounced level; acts on its rising edge.
- `count_up_sec` out 1: one-cycle seconds tick to the seconds counter.
- `stop` out 1: level, high in IDLE; holds the counters at zero.
- `rst_counters` out 1: one-cycle clear pulse to all counters.
- `lap_hold` out 1: high in LAP; the display shows the frozen value.
- `running` out 1: high in RUN or LAP (LED indicator).

## Operation

**Edge detection**
- Each button is registered once (`*_q`).
- `*_rise = btn & ~btn_q`.
- Priority when rises coincide: reset > start_stop > lap. Only the highest-priority rise that is legal in the current state acts; the others are dropped.

**States:** IDLE, RUN, LAP, PAUSE (2-bit encoding).
- IDLE:
  - start_stop → RUN.
  - lap and reset are ignored.
- RUN:
  - start_stop → PAUSE.
  - lap → LAP.
  - reset is ignored (the watch must be paused first).
- LAP:
  - lap → RUN.
  - start_stop → PAUSE (`lap_hold` drops).
  - reset is ignored.
- PAUSE:
  - start_stop → RUN.
  - reset → IDLE and asserts `rst_counters` for exactly one cycle.
  - lap is ignored.

**Prescaler**
- Width `$clog2(TICK_DIV)`.
- Counts 0..TICK_DIV-1 only in RUN and LAP.
- Holds its value in PAUSE, so no fractional second is lost across a pause.
- Cleared to 0 in IDLE and on the `rst_counters` cycle.
- `count_up_sec = (presc == TICK_DIV-1) && (state is RUN or LAP)`; `presc` then wraps to 0.

**Outputs**
- `stop`, `lap_hold` and `running` are decoded from the state register. They are glitch-free and carry no extra latency.
- `rst_counters` and `count_up_sec` are registered single-cycle pulses.

## Timing

**Reset values**
- State = IDLE, `presc` = 0, all `*_q` = 0.
- `stop` = 1; `count_up_sec`, `rst_counters`, `lap_hold`, `running` = 0.

**Latency**
- A button rise visible before CLK edge k changes the state at edge k.
- Decoded outputs change right after edge k.
- `rst_counters` is high for the cycle following edge k, coincident with state = IDLE.

**Tick timing**
- First tick after IDLE→RUN: `count_up_sec` is high TICK_DIV cycles after the state enters RUN.
- Subsequent ticks: every TICK_DIV cycles while in RUN or LAP.

**Boundary conditions**
- Pause on the tick cycle: the tick issued in that last RUN cycle still counts. `presc` wraps to 0 and then holds.
- Lap transitions do not disturb `presc` or tick spacing.
- A button held high produces one action only; a new rise requires a low sample in between.
- Asynchronous reset mid-RUN: returns immediately to the reset values; no `rst_counters` pulse is generated (the counters share `rst_n`).

## Structure

- Shared package `stp_pkg` holds:
  - state typedef `stp_state_t` (IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3);
  - default `TICK_DIV` constant, for reuse by the display mux and the TB.
- Sub-module `stp_tick_gen` contains the prescaler: inputs `en`, `clr`; output `tick`.
- The FSM and edge detection stay in `stp_ctrl`.

## Test plan

All scenarios use `TICK_DIV`=4.
- **Reset:** assert `rst_n`=0 mid-RUN → same cycle, `stop`=1, `running`=0, `count_up_sec`=0; after release, state IDLE, no ticks for 20 cycles.
- **Start and run:** rise on start_stop at edge k → `running`=1 after k; `count_up_sec` pulses at k+4, k+8, k+12, each one cycle wide.
- **Pause retains phase:** pause 2 cycles after a tick, wait 10 cycles, resume at edge m → next tick at m+2, not m+4.
- **Reset from PAUSE:** reset rise → `rst_counters` high for exactly one cycle, `stop`=1, `presc`=0. A reset rise in RUN or LAP → no pulse and no state change.
- **Lap:** from RUN, lap rise → `lap_hold`=1 and ticks continue every 4 cycles; second lap rise → `lap_hold`=0. start_stop while in LAP → PAUSE with `lap_hold`=0.
- **Coincident rises:** reset+start_stop in PAUSE → IDLE with `rst_counters` pulse; start_stop+lap in RUN → PAUSE; a held button → one transition only.
